// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin write-back arbiter feeding the 32x64 register file
//            write port from the EXU and a buffered, load-extended LSU stream.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int LSU_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               exu_valid,
    output logic                               exu_ready,
    input  logic [4:0]                         exu_rd,
    input  logic [63:0]                        exu_data,
    input  logic                               lsu_valid,
    output logic                               lsu_ready,
    input  logic [4:0]                         lsu_rd,
    input  logic [63:0]                        lsu_raw,
    input  logic [2:0]                         lsu_funct3,
    input  logic [2:0]                         lsu_offset,
    output logic [$clog2(LSU_DEPTH+1)-1:0]     lsu_q_count,
    output logic [4:0]                         RD,
    output logic [63:0]                        RD_Back,
    output logic                               Enable_Control
);

    localparam int       c_PTR_W   = $clog2(LSU_DEPTH);
    localparam int       c_CNT_W   = $clog2(LSU_DEPTH + 1);
    localparam logic [0:0] c_SRC_EXU = 1'b0;
    localparam logic [0:0] c_SRC_LSU = 1'b1;

    logic [4:0]          r_fifo_rd   [LSU_DEPTH];
    logic [63:0]         r_fifo_data [LSU_DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [0:0]          r_last_grant;

    logic [63:0]         w_shifted;
    logic [63:0]         w_load_data;
    logic                w_nonempty;
    logic                w_full;
    logic                w_enq;
    logic                w_grant_exu;
    logic                w_grant_lsu;

    // Load alignment and extension happen before the FIFO so the queue holds
    // final write-back values only.
    always_comb begin
        w_shifted   = lsu_raw >> {lsu_offset, 3'b000};
        w_load_data = w_shifted;
        case (lsu_funct3)
            3'b000:  w_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b100:  w_load_data = {56'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {48'd0, w_shifted[15:0]};
            3'b110:  w_load_data = {32'd0, w_shifted[31:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        w_nonempty  = (r_count != '0);
        w_full      = (r_count == c_CNT_W'(LSU_DEPTH));
        lsu_ready   = !w_full;
        lsu_q_count = r_count;
        w_enq       = lsu_valid && !w_full;
        // EXU is held off only when the LSU has work and EXU won last time.
        exu_ready   = !(w_nonempty && (r_last_grant == c_SRC_EXU));
        w_grant_exu = exu_valid && exu_ready;
        w_grant_lsu = w_nonempty && !w_grant_exu;
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_rd[r_wptr]   <= lsu_rd;
            r_fifo_data[r_wptr] <= w_load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_grant_lsu) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_enq, w_grant_lsu})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Writes to x0 still consume the result and load RD/RD_Back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RD             <= '0;
            RD_Back        <= '0;
            Enable_Control <= 1'b0;
            r_last_grant   <= c_SRC_LSU;
        end else if (w_grant_exu) begin
            RD             <= exu_rd;
            RD_Back        <= exu_data;
            Enable_Control <= (exu_rd != 5'd0);
            r_last_grant   <= c_SRC_EXU;
        end else if (w_grant_lsu) begin
            RD             <= r_fifo_rd[r_rptr];
            RD_Back        <= r_fifo_data[r_rptr];
            Enable_Control <= (r_fifo_rd[r_rptr] != 5'd0);
            r_last_grant   <= c_SRC_LSU;
        end else begin
            Enable_Control <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter with a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int LSU_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_raw;
    logic [2:0]  lsu_funct3;
    logic [2:0]  lsu_offset;
    logic [2:0]  lsu_q_count;
    logic [4:0]  RD;
    logic [63:0] RD_Back;
    logic        Enable_Control;

    regfile_wb_arbiter #(.LSU_DEPTH(LSU_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_raw(lsu_raw),
        .lsu_funct3(lsu_funct3), .lsu_offset(lsu_offset), .lsu_q_count(lsu_q_count),
        .RD(RD), .RD_Back(RD_Back), .Enable_Control(Enable_Control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        logic [2:0]  f3;
        logic [2:0]  off;
        logic [63:0] raw;
        logic [63:0] exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    ent_t        m_q[$];
    bit          m_last_exu;
    logic        exp_en;
    logic [4:0]  exp_rd;
    logic [63:0] exp_data;
    bit          m_g_exu;
    bit          m_g_lsu;
    bit          m_enq;

    logic [15:0] got[$];
    vec_t        vecs[10];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Extension from the load rules: keep nbytes of the shifted word, then sign-fill.
    function automatic logic [63:0] ref_ext(logic [2:0] f3, logic [2:0] off, logic [63:0] raw);
        logic [63:0] s;
        logic [63:0] mask;
        logic [63:0] v;
        int          nbytes;
        bit          uns;
        s      = raw >> (8 * off);
        nbytes = 1 << f3[1:0];
        uns    = f3[2] && (f3 != 3'd7);
        if (f3 == 3'd7 || nbytes == 8) return s;
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        v    = s & mask;
        if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic void m_reset();
        m_q.delete();
        m_last_exu = 1'b0;
        exp_en     = 1'b0;
        exp_rd     = '0;
        exp_data   = '0;
    endfunction

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic tick();
        bit          lsu_has;
        bit          e_rdy;
        bit          l_rdy;
        ent_t        ent;
        logic [4:0]  e_rd;
        logic [63:0] e_data;
        #1;
        lsu_has = (m_q.size() != 0);
        e_rdy   = !(lsu_has && m_last_exu);
        l_rdy   = (m_q.size() != LSU_DEPTH);
        chk("exu_ready", 64'(exu_ready), 64'(e_rdy));
        chk("lsu_ready", 64'(lsu_ready), 64'(l_rdy));
        if (exu_valid && lsu_has) m_g_exu = !m_last_exu;
        else                      m_g_exu = exu_valid;
        m_g_lsu  = lsu_has && !m_g_exu;
        m_enq    = lsu_valid && l_rdy;
        ent.rd   = lsu_rd;
        ent.data = ref_ext(lsu_funct3, lsu_offset, lsu_raw);
        e_rd     = exu_rd;
        e_data   = exu_data;
        @(posedge clk);
        if (m_g_exu) begin
            exp_rd = e_rd; exp_data = e_data; exp_en = (e_rd != 0); m_last_exu = 1'b1;
        end else if (m_g_lsu) begin
            ent_t h;
            h = m_q.pop_front();
            exp_rd = h.rd; exp_data = h.data; exp_en = (h.rd != 0); m_last_exu = 1'b0;
        end else begin
            exp_en = 1'b0;
        end
        if (m_enq) m_q.push_back(ent);
        #1;
        chk("wb_en",   64'(Enable_Control), 64'(exp_en));
        chk("wb_rd",   64'(RD),             64'(exp_rd));
        chk("wb_data", RD_Back,             exp_data);
        chk("q_count", 64'(lsu_q_count),    64'(m_q.size()));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; exu_valid = 1'b0; lsu_valid = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic record_lsu();
        if (Enable_Control && RD_Back[63:60] == 4'hA) got.push_back(RD_Back[15:0]);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ecnt;
        int pushed;
        bit reached;
        bit seen;
        bit acc_e;
        bit acc_l;

        vecs[0] = '{3'd0, 3'd1, 64'h0000_0000_0000_80FF, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1] = '{3'd4, 3'd1, 64'h0000_0000_0000_80FF, 64'h0000_0000_0000_0080};
        vecs[2] = '{3'd2, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
        vecs[3] = '{3'd6, 3'd4, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000};
        vecs[4] = '{3'd3, 3'd0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0};
        vecs[5] = '{3'd1, 3'd2, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_9ABC};
        vecs[6] = '{3'd5, 3'd2, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_9ABC};
        vecs[7] = '{3'd0, 3'd7, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0012};
        vecs[8] = '{3'd7, 3'd0, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001};
        vecs[9] = '{3'd7, 3'd4, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_DEAD_BEEF};

        exu_rd = '0; exu_data = '0; lsu_rd = '0; lsu_raw = '0;
        lsu_funct3 = '0; lsu_offset = '0;
        do_reset();

        // Reset state
        chk("rst_en",        64'(Enable_Control), 64'd0);
        chk("rst_rd",        64'(RD),             64'd0);
        chk("rst_data",      RD_Back,             64'd0);
        chk("rst_cnt",       64'(lsu_q_count),    64'd0);
        chk("rst_exu_ready", 64'(exu_ready),      64'd1);
        chk("rst_lsu_ready", 64'(lsu_ready),      64'd1);

        // Single EXU result
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 64'h1234;
        tick();
        exu_valid = 1'b0;
        chk("exu1_en",   64'(Enable_Control), 64'd1);
        chk("exu1_rd",   64'(RD),             64'd5);
        chk("exu1_data", RD_Back,             64'h1234);
        tick();
        chk("exu1_drop", 64'(Enable_Control), 64'd0);

        // Load extension table, one load at a time
        for (int i = 0; i < 10; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(i + 1);
            lsu_funct3 = vecs[i].f3; lsu_offset = vecs[i].off; lsu_raw = vecs[i].raw;
            tick();
            lsu_valid = 1'b0;
            chk("ext_nobypass", 64'(Enable_Control), 64'd0);
            tick();
            chk("ext_en",   64'(Enable_Control), 64'd1);
            chk("ext_data", RD_Back,             vecs[i].exp);
        end

        // Alternation with two queued loads and EXU held valid
        do_reset();
        ecnt = 0; got.delete();
        exu_valid = 1'b1; lsu_funct3 = 3'd3; lsu_offset = 3'd0;
        for (int c = 0; c < 8; c++) begin
            exu_rd = 5'(10 + ecnt); exu_data = 64'h0E00 + 64'(ecnt);
            lsu_valid = (c < 2); lsu_rd = 5'(20 + c); lsu_raw = 64'h0A00 + 64'(c);
            tick();
            if (m_g_exu) ecnt++;
            if (Enable_Control) got.push_back({11'd0, RD});
        end
        exu_valid = 1'b0; lsu_valid = 1'b0;
        chk("alt_count", 64'(got.size() >= 4), 64'd1);
        if (got.size() >= 4) begin
            chk("alt_w0", 64'(got[0]), 64'd10);
            chk("alt_w1", 64'(got[1]), 64'd20);
            chk("alt_w2", 64'(got[2]), 64'd11);
            chk("alt_w3", 64'(got[3]), 64'd21);
        end

        // Fill the FIFO under EXU pressure, then drain and check order
        do_reset();
        got.delete(); pushed = 0; reached = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd1; lsu_rd = 5'd2; lsu_funct3 = 3'd3; lsu_offset = 3'd0;
        for (int c = 0; c < 40 && !reached; c++) begin
            exu_data = 64'h5000 + 64'(c);
            lsu_valid = 1'b1; lsu_raw = 64'hA000_0000_0000_0000 | 64'(pushed);
            tick();
            record_lsu();
            if (m_enq) pushed++;
            if (m_q.size() == LSU_DEPTH) reached = 1'b1;
        end
        chk("full_reached", 64'(reached),     64'd1);
        chk("full_cnt",     64'(lsu_q_count), 64'd4);
        chk("full_ready",   64'(lsu_ready),   64'd0);
        for (int c = 0; c < 40 && pushed < 8; c++) begin
            exu_data = 64'h6000 + 64'(c);
            lsu_valid = 1'b1; lsu_raw = 64'hA000_0000_0000_0000 | 64'(pushed);
            tick();
            record_lsu();
            if (m_enq) pushed++;
        end
        exu_valid = 1'b0; lsu_valid = 1'b0;
        for (int c = 0; c < 20 && m_q.size() != 0; c++) begin
            tick();
            record_lsu();
        end
        chk("order_n", 64'(got.size()), 64'd8);
        for (int k = 0; k < got.size() && k < 8; k++) chk("order_k", 64'(got[k]), 64'(k));

        // x0 destinations are consumed without a write
        do_reset();
        seen = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 64'hBAD;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_raw = 64'hBAD2; lsu_funct3 = 3'd3;
        tick();
        acc_e = m_g_exu; acc_l = m_enq;
        seen = seen | Enable_Control;
        exu_valid = 1'b0; lsu_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            seen = seen | Enable_Control;
        end
        chk("x0_exu_acc", 64'(acc_e),       64'd1);
        chk("x0_lsu_acc", 64'(acc_l),       64'd1);
        chk("x0_no_en",   64'(seen),        64'd0);
        chk("x0_cnt",     64'(lsu_q_count), 64'd0);

        // Asynchronous reset with three entries queued
        do_reset();
        reached = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd3; lsu_rd = 5'd4; lsu_funct3 = 3'd3;
        for (int c = 0; c < 20 && !reached; c++) begin
            exu_data = 64'h7000 + 64'(c);
            lsu_valid = 1'b1; lsu_raw = 64'h100 + 64'(c);
            tick();
            if (m_q.size() == 3) reached = 1'b1;
        end
        chk("mid_built", 64'(reached), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cnt", 64'(lsu_q_count),    64'd0);
        chk("mid_rst_en",  64'(Enable_Control), 64'd0);
        chk("mid_rst_rd",  64'(RD),             64'd0);
        m_reset();
        exu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) tick();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            exu_valid  = 1'($urandom_range(0, 1));
            exu_rd     = 5'($urandom);
            exu_data   = {$urandom, $urandom};
            lsu_valid  = ($urandom_range(0, 3) != 0);
            lsu_rd     = 5'($urandom);
            lsu_raw    = {$urandom, $urandom};
            lsu_funct3 = 3'($urandom);
            lsu_offset = 3'($urandom);
            tick();
        end
        exu_valid = 1'b0; lsu_valid = 1'b0;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
